// File: rtl/inst_sram_resp_pkg.sv
// -----------------------------------------------------------------------------
// inst_sram_resp_pkg
// Shared definitions for the instruction SRAM responder slice:
//   - word / byte-enable widths
//   - default base byte address of word 0
//   - clear-sequence FSM state encodings (IDLE, CLEAR, READY)
//   - byte-merge helper used by the storage bank
// -----------------------------------------------------------------------------
package inst_sram_resp_pkg;

  localparam int          WORD_W            = 32;
  localparam int          BE_W              = 4;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_e;

  // Merge the enabled bytes of new_w into old_w.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_w,
    input logic [WORD_W-1:0] new_w,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] res;
    res = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/inst_sram_resp_sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
// DEPTH x 32-bit single-port storage with byte write enables and a registered,
// read-first output: on an enabled cycle the output register captures the word
// as it was before any write in that same cycle.
//
// Ports:
//   i_clk    clock
//   i_en     port active this cycle (read and/or write)
//   i_we     byte write enables, 0 = read only
//   i_addr   word index
//   i_wdata  write data, byte i on bits [8i+7:8i]
//   o_rdata  registered read data; holds when i_en = 0
// -----------------------------------------------------------------------------
module sram_bank
  import inst_sram_resp_pkg::*;
#(
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [BE_W-1:0]   i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // No reset on the array or output register: contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < BE_W; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_resp.sv
// -----------------------------------------------------------------------------
// inst_sram_resp
// Instruction SRAM responder. Decodes byte addresses relative to BASE_ADDR,
// serves reads with exactly one cycle latency (read-first on same-word
// write), returns 0 and raises a sticky error on out-of-range accesses, and
// counts accepted reads and writes.
//
// Handshake: a request is accepted on a rising edge when sram_en = 1 and
// busy = 0 (and reset is low). There is no back-pressure other than busy;
// an accepted request's response appears on sram_rdata after that edge and
// holds until the next accepted request.
//
// Build option: macro INST_SRAM_CLEAR_EN enables a post-reset clear sequence
// (IDLE -> CLEAR -> READY) that zeroes every word, one per cycle, while busy
// is held high for DEPTH cycles after reset release. Without it busy is tied
// low and the memory is undefined until written.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   sram_en        request this cycle
//   sram_we        byte write enables, 4'h0 = read
//   sram_addr      byte address, bits [1:0] ignored
//   sram_wdata     write data
//   sram_rdata     read data, valid the cycle after acceptance
//   busy           not accepting requests (clear sequence active)
//   addr_err       sticky out-of-range access flag
//   rd_cnt/wr_cnt  accepted read / write counters (wrap)
//   o_dbg_state    clear-sequence state (READY constant without the macro)
// -----------------------------------------------------------------------------
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sram_en,
  input  logic [BE_W-1:0]   sram_we,
  input  logic [31:0]       sram_addr,
  input  logic [WORD_W-1:0] sram_wdata,
  output logic [WORD_W-1:0] sram_rdata,
  output logic              busy,
  output logic              addr_err,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  output state_e            o_dbg_state
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

  // ---------------------------------------------------------------------------
  // Address decode: unsigned offset, so addresses below BASE_ADDR wrap to a
  // huge offset and fall out of range naturally.
  // ---------------------------------------------------------------------------
  logic [31:0]   w_offset;
  logic          w_in_range;
  logic [AW-1:0] w_idx;
  logic          w_busy;
  logic          w_accept;
  logic          w_is_write;

  assign w_offset   = sram_addr - BASE_ADDR;
  assign w_in_range = (w_offset < SPAN);
  assign w_idx      = w_offset[AW+1:2];
  assign w_accept   = sram_en && !w_busy && !reset;
  assign w_is_write = (sram_we != '0);

  // ---------------------------------------------------------------------------
  // Bank port selection
  // ---------------------------------------------------------------------------
  logic              w_bank_en;
  logic [BE_W-1:0]   w_bank_we;
  logic [AW-1:0]     w_bank_addr;
  logic [WORD_W-1:0] w_bank_wdata;
  logic [WORD_W-1:0] w_bank_rdata;
  logic              w_req_bank;

  assign w_req_bank = w_accept && w_in_range;

`ifdef INST_SRAM_CLEAR_EN
  state_e        r_state;
  logic [AW-1:0] r_clr_idx;
  logic          r_busy;
  logic          w_clr_we;

  // The clear engine owns the bank whenever it is not READY. Word 0 is
  // written on the IDLE->CLEAR edge so the whole sequence, and busy, spans
  // exactly DEPTH cycles after reset release.
  assign w_clr_we = !reset && (r_state != ST_READY);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_idx <= '0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_CLEAR;
          r_clr_idx <= AW'(1);
        end
        ST_CLEAR: begin
          if (r_clr_idx == AW'(DEPTH - 1)) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end else begin
            r_clr_idx <= r_clr_idx + AW'(1);
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_busy       = r_busy;
  assign o_dbg_state  = r_state;
  assign w_bank_en    = w_clr_we || w_req_bank;
  assign w_bank_we    = w_clr_we ? {BE_W{1'b1}} : (w_req_bank ? sram_we : '0);
  assign w_bank_addr  = w_clr_we ? r_clr_idx : w_idx;
  assign w_bank_wdata = w_clr_we ? '0 : sram_wdata;
`else
  assign w_busy       = 1'b0;
  assign o_dbg_state  = ST_READY;
  assign w_bank_en    = w_req_bank;
  assign w_bank_we    = w_req_bank ? sram_we : '0;
  assign w_bank_addr  = w_idx;
  assign w_bank_wdata = sram_wdata;
`endif

  assign busy = w_busy;

  sram_bank #(
    .DEPTH (DEPTH)
  ) u_bank (
    .i_clk   (clk),
    .i_en    (w_bank_en),
    .i_we    (w_bank_we),
    .i_addr  (w_bank_addr),
    .i_wdata (w_bank_wdata),
    .o_rdata (w_bank_rdata)
  );

  // ---------------------------------------------------------------------------
  // Response select: r_zero forces 0 after reset and after an out-of-range
  // access; it only changes on acceptance, so the output holds otherwise.
  // The bank register may be refreshed by clear writes, but r_zero stays set
  // from reset through the clear sequence, so that is never visible.
  // ---------------------------------------------------------------------------
  logic        r_zero;
  logic        r_addr_err;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_zero     <= 1'b1;
      r_addr_err <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else if (w_accept) begin
      r_zero <= !w_in_range;
      if (!w_in_range) r_addr_err <= 1'b1;
      if (w_is_write) r_wr_cnt <= r_wr_cnt + 32'd1;
      else            r_rd_cnt <= r_rd_cnt + 32'd1;
    end
  end

  assign sram_rdata = r_zero ? '0 : w_bank_rdata;
  assign addr_err   = r_addr_err;
  assign rd_cnt     = r_rd_cnt;
  assign wr_cnt     = r_wr_cnt;

endmodule

// File: tb/tb_inst_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_sram_resp
// Self-checking bench for inst_sram_resp (DEPTH = 16). A behavioural model
// (word array + counters + sticky flag) predicts every response; directed
// scenarios plus a randomized run are compared against it. The clear-sequence
// scenario is compiled in when INST_SRAM_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_inst_sram_resp;
  import inst_sram_resp_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam logic [31:0] SPAN  = 32'(DEPTH) * 32'd4;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        busy;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  state_e      dbg_state;

  always #5 clk = ~clk;

  inst_sram_resp #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sram_en     (sram_en),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rdata  (sram_rdata),
    .busy        (busy),
    .addr_err    (addr_err),
    .rd_cnt      (rd_cnt),
    .wr_cnt      (wr_cnt),
    .o_dbg_state (dbg_state)
  );

  // reference model
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;
  logic [31:0] m_rd;
  logic [31:0] m_wr;
  logic        m_err;
  int          m_clear_left;

  // scoreboard
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  // One clock: drive inputs, take the edge, sample 1 time unit later and
  // advance the model with the same request.
  task automatic step(input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    int          idx;
    sram_en    = en;
    sram_we    = we;
    sram_addr  = addr;
    sram_wdata = wdata;
    @(posedge clk);
    #1;
    if (en && m_clear_left == 0) begin
      off = addr - BASE;
      if (off < SPAN) begin
        idx     = int'(off / 4);
        m_rdata = m_mem[idx];
        for (int b = 0; b < 4; b++)
          if (we[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        m_rdata = 32'h0;
        m_err   = 1'b1;
      end
      if (we == 4'h0) m_rd = m_rd + 32'd1;
      else            m_wr = m_wr + 32'd1;
    end
    if (m_clear_left > 0) m_clear_left--;
    sram_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    sram_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset   = 1'b0;
    m_rdata = 32'h0;
    m_rd    = 32'h0;
    m_wr    = 32'h0;
    m_err   = 1'b0;
`ifdef INST_SRAM_CLEAR_EN
    m_clear_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
`else
    m_clear_left = 0;
`endif
  endtask

  // m_clear_left drops by one per step, so this is bounded by DEPTH cycles.
  task automatic reset_and_ready();
    do_reset();
    while (m_clear_left > 0) idle(1);
  endtask

  // ---------------------------------------------------------------------------
  // scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (sram_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want %h", sram_rdata, 32'h0);
    end
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_addr_err: got %b want 0", addr_err);
    end
    n_checks++;
    if (rd_cnt !== 32'h0 || wr_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
    end
    n_checks++;
    if (busy !== (m_clear_left != 0)) begin
      n_fail++; $display("FAIL reset_busy: got %b want %b", busy, m_clear_left != 0);
    end
  endtask

`ifdef INST_SRAM_CLEAR_EN
  // Counts busy cycles from the current point while offering writes that
  // must be ignored; returns the number of cycles busy was seen high.
  task automatic count_busy(output int cnt);
    cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (busy === 1'b1) cnt++;
      step(m_clear_left > 0, 4'hf, BASE + 32'(4 * (i % DEPTH)), 32'hffff_ffff);
    end
  endtask

  task automatic test_clear();
    int cnt;
    do_reset();
    count_busy(cnt);
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++; $display("FAIL clear_busy_len: got %0d want %0d", cnt, DEPTH);
    end
    n_checks++;
    if (wr_cnt !== 32'h0) begin
      n_fail++; $display("FAIL clear_ignored: got wr_cnt=%0d want 0", wr_cnt);
    end
    n_checks++;
    if (dbg_state !== ST_READY) begin
      n_fail++; $display("FAIL clear_state: got %0d want %0d", dbg_state, ST_READY);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      n_checks++;
      if (sram_rdata !== 32'h0) begin
        n_fail++; $display("FAIL clear_word%0d: got %h want 0", i, sram_rdata);
      end
    end
    // reset pulsed at clear cycle 5 restarts the full sequence
    do_reset();
    idle(5);
    do_reset();
    count_busy(cnt);
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++; $display("FAIL clear_restart_len: got %0d want %0d", cnt, DEPTH);
    end
  endtask
`endif

  task automatic test_basic();
    reset_and_ready();
    step(1'b1, 4'hf, BASE, 32'hdead_beef);
    step(1'b1, 4'h0, BASE, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'hdead_beef) begin
      n_fail++; $display("FAIL basic_rdata: got %h want deadbeef", sram_rdata);
    end
    n_checks++;
    if (wr_cnt !== 32'd1 || rd_cnt !== 32'd1) begin
      n_fail++; $display("FAIL basic_counts: got rd=%0d wr=%0d want 1/1", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_partial();
    step(1'b1, 4'hf, BASE + 32'h10, 32'h1122_3344);
    step(1'b1, 4'h2, BASE + 32'h10, 32'h0000_aa00);
    step(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h1122_aa44) begin
      n_fail++; $display("FAIL partial_write: got %h want 1122aa44", sram_rdata);
    end
  endtask

  task automatic test_read_during_write();
    step(1'b1, 4'hf, BASE + 32'h8, 32'h7);
    step(1'b1, 4'hf, BASE + 32'h8, 32'h5);
    n_checks++;
    if (sram_rdata !== 32'h7) begin
      n_fail++; $display("FAIL rdw_old: got %h want 7", sram_rdata);
    end
    step(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h5) begin
      n_fail++; $display("FAIL rdw_new: got %h want 5", sram_rdata);
    end
  endtask

  task automatic test_out_of_range();
    reset_and_ready();
    step(1'b1, 4'hf, BASE, 32'hcafe_f00d);
    step(1'b1, 4'h0, 32'h1bff_fffc, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h0 || addr_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_below: got rdata=%h err=%b want 0/1", sram_rdata, addr_err);
    end
    step(1'b1, 4'h0, BASE, 32'h0);
    step(1'b1, 4'h0, BASE + SPAN, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'h0) begin
      n_fail++; $display("FAIL oor_above: got %h want 0", sram_rdata);
    end
    idle(10);
    n_checks++;
    if (addr_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_sticky: got %b want 1", addr_err);
    end
    n_checks++;
    if (rd_cnt !== 32'd3 || wr_cnt !== 32'd1) begin
      n_fail++; $display("FAIL oor_counts: got rd=%0d wr=%0d want 3/1", rd_cnt, wr_cnt);
    end
    // out-of-range write must not alias onto any word
    step(1'b1, 4'hf, BASE + SPAN, 32'h1234_5678);
    step(1'b1, 4'h0, BASE, 32'h0);
    n_checks++;
    if (sram_rdata !== 32'hcafe_f00d) begin
      n_fail++; $display("FAIL oor_no_write: got %h want cafef00d", sram_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) step(1'b1, 4'hf, BASE + 32'(4 * i), 32'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'h0, BASE + 32'(4 * i), 32'h0);
      exp = exp_q.pop_front();
      n_checks++;
      if (sram_rdata !== exp) begin
        n_fail++; $display("FAIL stream_%0d: got %h want %h", i, sram_rdata, exp);
      end
      if (i == 3) begin
        idle(2);
        n_checks++;
        if (sram_rdata !== exp) begin
          n_fail++; $display("FAIL stream_hold: got %h want %h", sram_rdata, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [3:0]  we;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 4'hf, BASE + 32'(4 * i), $urandom);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 32'(4 * $urandom_range(1, 8));
        1:       addr = BASE + SPAN + 32'(4 * $urandom_range(0, 8));
        default: addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      endcase
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      step($urandom_range(0, 4) != 0, we, addr, $urandom);
      n_checks++;
      if (sram_rdata !== m_rdata || addr_err !== m_err) begin
        n_fail++;
        $display("FAIL random_%0d: got rdata=%h err=%b want %h/%b", n, sram_rdata, addr_err, m_rdata, m_err);
      end
    end
    n_checks++;
    if (rd_cnt !== m_rd || wr_cnt !== m_wr) begin
      n_fail++; $display("FAIL random_counts: got rd=%0d wr=%0d want %0d/%0d", rd_cnt, wr_cnt, m_rd, m_wr);
    end
  endtask

  // ---------------------------------------------------------------------------
  // sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    sram_en      = 1'b0;
    sram_we      = 4'h0;
    sram_addr    = 32'h0;
    sram_wdata   = 32'h0;
    m_clear_left = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    test_reset();
`ifdef INST_SRAM_CLEAR_EN
    test_clear();
`endif
    test_basic();
    test_partial();
    test_read_during_write();
    test_out_of_range();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
